// File: rtl/core_pkg.sv
// Shared core types for the data-memory path: OBI FSM states, access sizes,
// exception causes, and LSU lane helpers.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DUMPING    = 2'b11
    } OBI_state_t;

    // Encoding 2'b11 is reserved and behaves like WORD everywhere below.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } data_type_t;

    localparam logic [4:0] EXC_CAUSE_LOAD_ADDR_MISAL  = 5'h04;
    localparam logic [4:0] EXC_CAUSE_LOAD_FAULT       = 5'h05;
    localparam logic [4:0] EXC_CAUSE_STORE_ADDR_MISAL = 5'h06;
    localparam logic [4:0] EXC_CAUSE_STORE_FAULT      = 5'h07;

    function automatic logic [3:0] lsu_be_gen(input data_type_t dtype, input logic [1:0] off);
        case (dtype)
            BYTE:      lsu_be_gen = 4'b0001 << off;
            HALF_WORD: lsu_be_gen = 4'b0011 << off;
            default:   lsu_be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input data_type_t dtype, input logic [1:0] off);
        case (dtype)
            BYTE:      lsu_misaligned = 1'b0;
            HALF_WORD: lsu_misaligned = off[0];
            default:   lsu_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata_rep(input data_type_t dtype, input logic [31:0] wdata);
        case (dtype)
            BYTE:      lsu_wdata_rep = {4{wdata[7:0]}};
            HALF_WORD: lsu_wdata_rep = {2{wdata[15:0]}};
            default:   lsu_wdata_rep = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: shifts the addressed lanes down to bit 0
// and zero- or sign-extends sub-word loads.
module lsu_load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  data_type_t  type_i,
    input  logic        sext_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (type_i)
            BYTE:      data_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            HALF_WORD: data_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_obi.sv
// Load/store unit: one outstanding OBI transaction, misalignment and bus-fault
// exceptions, and flush handling that silently drains a killed response.
module lsu_obi
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    we_i,
    input  data_type_t              data_type_i,
    input  logic                    sign_ext_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    flush_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    exc_valid_o,
    output logic [4:0]              exc_cause_o,
    output logic [ADDR_WIDTH-1:0]   exc_tval_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    input  logic                    data_err_i
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("lsu_obi: DATA_WIDTH must be 32");
    end

    OBI_state_t            state_q, state_d;
    logic                  kill_q, kill_d;
    logic                  we_q, we_d;
    data_type_t            type_q, type_d;
    logic                  sext_q, sext_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  exc_pend_q, exc_pend_d;
    logic [4:0]            exc_cause_q, exc_cause_d;
    logic [ADDR_WIDTH-1:0] exc_tval_q, exc_tval_d;
    logic                  resp_ok, resp_err;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        we_d        = we_q;
        type_d      = type_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        exc_pend_d  = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_tval_d  = exc_tval_q;
        resp_ok     = 1'b0;
        resp_err    = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush in the acceptance cycle wins: the request is not taken.
                if (req_valid_i && !flush_i) begin
                    if (lsu_misaligned(data_type_i, addr_i[1:0])) begin
                        exc_pend_d  = 1'b1;
                        exc_cause_d = we_i ? EXC_CAUSE_STORE_ADDR_MISAL : EXC_CAUSE_LOAD_ADDR_MISAL;
                        exc_tval_d  = addr_i;
                    end else begin
                        state_d = REQUESTING;
                        kill_d  = 1'b0;
                        we_d    = we_i;
                        type_d  = data_type_i;
                        sext_d  = sign_ext_i;
                        addr_d  = addr_i;
                        be_d    = lsu_be_gen(data_type_i, addr_i[1:0]);
                        wdata_d = lsu_wdata_rep(data_type_i, wdata_i);
                    end
                end
            end
            REQUESTING: begin
                if (flush_i) kill_d = 1'b1;
                if (data_gnt_i) state_d = (kill_q || flush_i) ? DUMPING : WAITING;
            end
            WAITING: begin
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        resp_err = data_err_i;
                        resp_ok  = !data_err_i;
                    end
                end else if (flush_i) begin
                    state_d = DUMPING;
                end
            end
            DUMPING: begin
                if (data_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            we_q        <= 1'b0;
            type_q      <= BYTE;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            exc_pend_q  <= 1'b0;
            exc_cause_q <= '0;
            exc_tval_q  <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            we_q        <= we_d;
            type_q      <= type_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            exc_pend_q  <= exc_pend_d;
            exc_cause_q <= exc_cause_d;
            exc_tval_q  <= exc_tval_d;
        end
    end

    lsu_load_align u_load_align (
        .rdata_i  (data_rdata_i),
        .offset_i (addr_q[1:0]),
        .type_i   (type_q),
        .sext_i   (sext_q),
        .data_o   (load_data)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign data_req_o   = (state_q == REQUESTING);
    assign data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    // Misalignment pulses come from a register; bus faults are combinational with rvalid.
    assign rvalid_o    = resp_ok;
    assign rdata_o     = (resp_ok && !we_q) ? load_data : '0;
    assign exc_valid_o = exc_pend_q | resp_err;
    assign exc_cause_o = resp_err   ? (we_q ? EXC_CAUSE_STORE_FAULT : EXC_CAUSE_LOAD_FAULT) :
                         exc_pend_q ? exc_cause_q : 5'h00;
    assign exc_tval_o  = resp_err   ? addr_q :
                         exc_pend_q ? exc_tval_q : '0;

    a_reserved_type: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_valid_i && req_ready_o) |-> (data_type_i != data_type_t'(2'b11)));
    a_rvalid_unexpected: assert property (@(posedge clk_i) disable iff (rst_i)
        data_rvalid_i |-> (state_q == WAITING || state_q == DUMPING));
    a_pulse_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rvalid_o && exc_valid_o));

endmodule

// File: tb/tb_lsu_obi.sv
// Directed bench for lsu_obi: a table of single accesses plus hand-written
// sequences for stalls and flushes.
module tb_lsu_obi;
    import core_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        we_i = 1'b0;
    data_type_t  data_type_i = WORD;
    logic        sign_ext_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        exc_valid_o;
    logic [4:0]  exc_cause_o;
    logic [31:0] exc_tval_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    lsu_obi #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .we_i         (we_i),
        .data_type_i  (data_type_i),
        .sign_ext_i   (sign_ext_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .exc_valid_o  (exc_valid_o),
        .exc_cause_o  (exc_cause_o),
        .exc_tval_o   (exc_tval_o),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i),
        .data_err_i   (data_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        data_type_t  dtype;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        misal;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_cause;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic presentRequest(input logic we, input data_type_t dt, input logic sext,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        we_i        = we;
        data_type_i = dt;
        sign_ext_i  = sext;
        addr_i      = addr;
        wdata_i     = wdata;
    endtask

    // One complete access, gnt and rvalid each the cycle after they become possible.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk_i);
        checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        presentRequest(v.we, v.dtype, v.sext, v.addr, v.wdata);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (v.misal) begin
            checkOutput({tag, "_no_req"}, 32'(data_req_o), 32'd0);
            checkOutput({tag, "_exc_valid"}, 32'(exc_valid_o), 32'd1);
            checkOutput({tag, "_exc_cause"}, 32'(exc_cause_o), 32'(v.exp_cause));
            checkOutput({tag, "_exc_tval"}, exc_tval_o, v.addr);
            @(negedge clk_i);
            checkOutput({tag, "_exc_pulse_end"}, 32'(exc_valid_o), 32'd0);
            checkOutput({tag, "_still_no_req"}, 32'(data_req_o), 32'd0);
            return;
        end
        checkOutput({tag, "_req"}, 32'(data_req_o), 32'd1);
        checkOutput({tag, "_addr"}, data_addr_o, v.addr & 32'hFFFF_FFFC);
        checkOutput({tag, "_we"}, 32'(data_we_o), 32'(v.we));
        checkOutput({tag, "_be"}, 32'(data_be_o), 32'(v.exp_be));
        if (v.we) checkOutput({tag, "_wdata"}, data_wdata_o, v.exp_wdata);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        checkOutput({tag, "_req_dropped"}, 32'(data_req_o), 32'd0);
        checkOutput({tag, "_early_rvalid"}, 32'(rvalid_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        data_err_i    = v.err;
        #1;
        checkOutput({tag, "_rvalid"}, 32'(rvalid_o), 32'(!v.err));
        checkOutput({tag, "_exc_valid"}, 32'(exc_valid_o), 32'(v.err));
        checkOutput({tag, "_rdata"}, rdata_o, v.exp_rdata);
        if (v.err) begin
            checkOutput({tag, "_exc_cause"}, 32'(exc_cause_o), 32'(v.exp_cause));
            checkOutput({tag, "_exc_tval"}, exc_tval_o, v.addr);
        end
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        #1;
        checkOutput({tag, "_rvalid_end"}, 32'(rvalid_o), 32'd0);
        checkOutput({tag, "_exc_end"}, 32'(exc_valid_o), 32'd0);
        checkOutput({tag, "_back_idle"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, WORD,      1'b0, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF, 5'h00};
        vecs[1]  = '{1'b0, BYTE,      1'b1, 32'h0000_1003, 32'h0,         32'h80FF_0000, 1'b0, 1'b0, 4'h8, 32'h0,         32'hFFFF_FF80, 5'h00};
        vecs[2]  = '{1'b0, BYTE,      1'b0, 32'h0000_1003, 32'h0,         32'h80FF_0000, 1'b0, 1'b0, 4'h8, 32'h0,         32'h0000_0080, 5'h00};
        vecs[3]  = '{1'b0, HALF_WORD, 1'b1, 32'h0000_1002, 32'h0,         32'h80FF_0000, 1'b0, 1'b0, 4'hC, 32'h0,         32'hFFFF_80FF, 5'h00};
        vecs[4]  = '{1'b0, HALF_WORD, 1'b0, 32'h0000_1000, 32'h0,         32'h1234_8765, 1'b0, 1'b0, 4'h3, 32'h0,         32'h0000_8765, 5'h00};
        vecs[5]  = '{1'b0, BYTE,      1'b1, 32'h0000_1001, 32'h0,         32'h0000_7F00, 1'b0, 1'b0, 4'h2, 32'h0,         32'h0000_007F, 5'h00};
        vecs[6]  = '{1'b1, WORD,      1'b0, 32'h0000_2004, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'hF, 32'h1122_3344, 32'h0,         5'h00};
        vecs[7]  = '{1'b1, BYTE,      1'b0, 32'h0000_2001, 32'h0000_00A5, 32'h0,         1'b0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0,         5'h00};
        vecs[8]  = '{1'b1, BYTE,      1'b0, 32'h0000_3003, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 4'h8, 32'h7878_7878, 32'h0,         5'h00};
        vecs[9]  = '{1'b1, HALF_WORD, 1'b0, 32'h0000_2006, 32'h0000_BEEF, 32'h0,         1'b0, 1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0,         5'h00};
        vecs[10] = '{1'b0, WORD,      1'b1, 32'h0000_3001, 32'h0,         32'h0,         1'b0, 1'b1, 4'h0, 32'h0,         32'h0,         5'h04};
        vecs[11] = '{1'b1, WORD,      1'b0, 32'h0000_3002, 32'h0,         32'h0,         1'b0, 1'b1, 4'h0, 32'h0,         32'h0,         5'h06};
        vecs[12] = '{1'b0, HALF_WORD, 1'b1, 32'h0000_3003, 32'h0,         32'h0,         1'b0, 1'b1, 4'h0, 32'h0,         32'h0,         5'h04};
        vecs[13] = '{1'b0, WORD,      1'b0, 32'h0000_4000, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0, 4'hF, 32'h0,         32'h0,         5'h05};
        vecs[14] = '{1'b1, WORD,      1'b0, 32'h0000_4008, 32'hCAFE_F00D, 32'h0,         1'b1, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0,         5'h07};

        repeat (2) @(negedge clk_i);
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_req", 32'(data_req_o), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("reset_exc", 32'(exc_valid_o), 32'd0);
        checkOutput("reset_addr", data_addr_o, 32'h0);
        checkOutput("reset_be", 32'(data_be_o), 32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        // Store with grant withheld for three cycles: bus outputs must not move.
        @(negedge clk_i);
        presentRequest(1'b1, HALF_WORD, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            checkOutput($sformatf("stall%0d_req", c), 32'(data_req_o), 32'd1);
            checkOutput($sformatf("stall%0d_addr", c), data_addr_o, 32'h0000_2000);
            checkOutput($sformatf("stall%0d_be", c), 32'(data_be_o), 32'hC);
            checkOutput($sformatf("stall%0d_wdata", c), data_wdata_o, 32'hABCD_ABCD);
        end
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        #1;
        checkOutput("stall_rvalid", 32'(rvalid_o), 32'd1);
        checkOutput("stall_rdata_zero", rdata_o, 32'h0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0;

        // Flush while waiting for the response: the late response is swallowed.
        presentRequest(1'b0, WORD, 1'b0, 32'h0000_5000, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        data_gnt_i  = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        flush_i    = 1'b1;
        #1;
        checkOutput("flushw_no_rvalid", 32'(rvalid_o), 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flushw_dumping_busy", 32'(req_ready_o), 32'd0);
        checkOutput("flushw_dumping_no_req", 32'(data_req_o), 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_AAAA;
        #1;
        checkOutput("flushw_resp_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("flushw_resp_exc", 32'(exc_valid_o), 32'd0);
        checkOutput("flushw_resp_rdata", rdata_o, 32'h0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        applyStimulus(vecs[0], 100);

        // Flush before grant: the transaction is still granted, then drained.
        @(negedge clk_i);
        presentRequest(1'b0, WORD, 1'b0, 32'h0000_6000, 32'h0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flushr_req_held", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        checkOutput("flushr_dumping_busy", 32'(req_ready_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        #1;
        checkOutput("flushr_resp_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("flushr_resp_exc", 32'(exc_valid_o), 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        checkOutput("flushr_idle", 32'(req_ready_o), 32'd1);

        // Flush in the acceptance cycle: nothing is taken.
        presentRequest(1'b0, WORD, 1'b0, 32'h0000_7000, 32'h0);
        flush_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        checkOutput("flusha_no_req", 32'(data_req_o), 32'd0);
        checkOutput("flusha_ready", 32'(req_ready_o), 32'd1);
        checkOutput("flusha_no_exc", 32'(exc_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
